// File: rtl/reorder_buffer_pkg.sv
// Shared widths and record layouts for the reorder buffer slice.
package reorder_buffer_pkg;
  localparam int TAG_W  = 5;
  localparam int DATA_W = 32;
  localparam int REG_W  = 5;
  localparam int DEPTH  = 2 ** TAG_W;

  typedef struct packed {
    logic              valid;
    logic              done;
    logic              we;
    logic [REG_W-1:0]  dst;
    logic [DATA_W-1:0] data;
  } rob_entry_t;

  typedef struct packed {
    logic              valid;
    logic              we;
    logic [REG_W-1:0]  dst;
    logic [DATA_W-1:0] data;
    logic [TAG_W-1:0]  tag;
  } rob_commit_t;
endpackage

// File: rtl/reorder_buffer_if.sv
// Dispatch / writeback / operand-read / commit signal bundle of the reorder buffer.
interface reorder_buffer_if;
  import reorder_buffer_pkg::*;

  logic              flush;
  logic              alloc_valid;
  logic              alloc_we;
  logic [REG_W-1:0]  alloc_dst;
  logic              alloc_ready;
  logic [TAG_W-1:0]  alloc_tag;
  logic              wb_we;
  logic [TAG_W-1:0]  wb_tag;
  logic [REG_W-1:0]  wb_dst;
  logic [DATA_W-1:0] wb_data;
  logic [TAG_W-1:0]  rd_tag;
  logic              rd_done;
  logic [DATA_W-1:0] rd_data;
  logic              commit_valid;
  logic              commit_we;
  logic [REG_W-1:0]  commit_dst;
  logic [DATA_W-1:0] commit_data;
  logic [TAG_W-1:0]  commit_tag;
  logic [TAG_W:0]    count;

  modport slave (
    input  flush, alloc_valid, alloc_we, alloc_dst, wb_we, wb_tag, wb_dst, wb_data, rd_tag,
    output alloc_ready, alloc_tag, rd_done, rd_data,
           commit_valid, commit_we, commit_dst, commit_data, commit_tag, count
  );

  modport master (
    output flush, alloc_valid, alloc_we, alloc_dst, wb_we, wb_tag, wb_dst, wb_data, rd_tag,
    input  alloc_ready, alloc_tag, rd_done, rd_data,
           commit_valid, commit_we, commit_dst, commit_data, commit_tag, count
  );
endinterface

// File: rtl/reorder_buffer_rob_ptr.sv
// Circular index with an extra wrap bit; clear has priority over increment.
module rob_ptr #(
  parameter int W = 5
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       clr_i,
  input  logic       inc_i,
  output logic [W:0] ptr_o
);
  logic [W:0] ptr_q, ptr_d;

  always_comb begin
    ptr_d = ptr_q;
    if (clr_i)      ptr_d = '0;
    else if (inc_i) ptr_d = ptr_q + (W+1)'(1);
  end

  always_ff @(posedge clk) begin
    if (rst) ptr_q <= '0;
    else     ptr_q <= ptr_d;
  end

  assign ptr_o = ptr_q;
endmodule

// File: rtl/reorder_buffer.sv
// In-order commit buffer: allocate at tail, complete by tag, retire one per cycle from head.
module reorder_buffer
  import reorder_buffer_pkg::*;
(
  input  logic            clk,
  input  logic            rst,
  reorder_buffer_if.slave rob
);
  logic [TAG_W:0]   head_q, tail_q;
  logic [TAG_W-1:0] head_idx, tail_idx;
  logic             full, do_alloc, do_wb, do_commit;
  rob_entry_t       entries_q [DEPTH];
  rob_commit_t      commit_q, commit_d;

  rob_ptr #(.W(TAG_W)) u_head (
    .clk(clk), .rst(rst), .clr_i(rob.flush), .inc_i(do_commit), .ptr_o(head_q)
  );
  rob_ptr #(.W(TAG_W)) u_tail (
    .clk(clk), .rst(rst), .clr_i(rob.flush), .inc_i(do_alloc), .ptr_o(tail_q)
  );

  assign head_idx  = head_q[TAG_W-1:0];
  assign tail_idx  = tail_q[TAG_W-1:0];
  // Same index, opposite wrap bit: every slot is occupied.
  assign full      = (head_q ^ tail_q) == (TAG_W+1)'(DEPTH);
  assign do_alloc  = rob.alloc_valid && !full;
  assign do_wb     = rob.wb_we && entries_q[rob.wb_tag].valid;
  assign do_commit = entries_q[head_idx].valid && entries_q[head_idx].done;

  always_ff @(posedge clk) begin
    if (rst || rob.flush) begin
      for (int i = 0; i < DEPTH; i++) entries_q[i] <= '0;
    end else begin
      if (do_wb) begin
        entries_q[rob.wb_tag].done <= 1'b1;
        entries_q[rob.wb_tag].data <= rob.wb_data;
      end
      // Committed entry is already done, so clearing after wb is safe; alloc never hits head.
      if (do_commit) entries_q[head_idx] <= '0;
      if (do_alloc)
        entries_q[tail_idx] <= '{valid: 1'b1, done: 1'b0, we: rob.alloc_we,
                                 dst: rob.alloc_dst, data: '0};
    end
  end

  always_comb begin
    commit_d = '0;
    if (do_commit) begin
      commit_d.valid = 1'b1;
      commit_d.we    = entries_q[head_idx].we;
      commit_d.dst   = entries_q[head_idx].dst;
      commit_d.data  = entries_q[head_idx].data;
      commit_d.tag   = head_idx;
    end
  end

  always_ff @(posedge clk) begin
    if (rst || rob.flush) commit_q <= '0;
    else                  commit_q <= commit_d;
  end

  always_ff @(posedge clk) begin
    if (!rst && !rob.flush && do_wb)
      assert (rob.wb_dst == entries_q[rob.wb_tag].dst);
  end

  assign rob.alloc_ready  = !full;
  assign rob.alloc_tag    = tail_idx;
  assign rob.count        = tail_q - head_q;
  assign rob.rd_done      = entries_q[rob.rd_tag].valid && entries_q[rob.rd_tag].done;
  assign rob.rd_data      = entries_q[rob.rd_tag].data;
  assign rob.commit_valid = commit_q.valid;
  assign rob.commit_we    = commit_q.we;
  assign rob.commit_dst   = commit_q.dst;
  assign rob.commit_data  = commit_q.data;
  assign rob.commit_tag   = commit_q.tag;
endmodule

// File: tb/tb_reorder_buffer.sv
// Directed bench for reorder_buffer: vector table plus full/wrap/flush sequences.
module tb_reorder_buffer;
  import reorder_buffer_pkg::*;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  reorder_buffer_if bus();
  reorder_buffer dut (.clk(clk), .rst(rst), .rob(bus));

  typedef struct {
    logic        rst, flush, av, awe;
    logic [4:0]  adst;
    logic        wbwe;
    logic [4:0]  wbtag, wbdst;
    logic [31:0] wbdata;
    logic [4:0]  rdtag;
    logic        chk;
    logic        e_ready;
    logic [4:0]  e_tag;
    logic        e_rddone;
    logic [31:0] e_rddata;
    logic        e_cv, e_cwe;
    logic [4:0]  e_cdst;
    logic [31:0] e_cdata;
    logic [4:0]  e_ctag;
    logic [5:0]  e_count;
  } vec_t;

  localparam int NV = 20;
  vec_t vt [NV];
  int n_pass = 0;
  int n_total = 0;

  function automatic vec_t row(
    input logic r, fl, av, awe, input logic [4:0] adst,
    input logic wbwe, input logic [4:0] wbtag, wbdst, input logic [31:0] wbdata,
    input logic [4:0] rdtag, input logic chk, input logic e_ready, input logic [4:0] e_tag,
    input logic e_rddone, input logic [31:0] e_rddata, input logic e_cv, e_cwe,
    input logic [4:0] e_cdst, input logic [31:0] e_cdata, input logic [4:0] e_ctag,
    input logic [5:0] e_count);
    vec_t v;
    v.rst = r; v.flush = fl; v.av = av; v.awe = awe; v.adst = adst;
    v.wbwe = wbwe; v.wbtag = wbtag; v.wbdst = wbdst; v.wbdata = wbdata; v.rdtag = rdtag;
    v.chk = chk; v.e_ready = e_ready; v.e_tag = e_tag; v.e_rddone = e_rddone;
    v.e_rddata = e_rddata; v.e_cv = e_cv; v.e_cwe = e_cwe; v.e_cdst = e_cdst;
    v.e_cdata = e_cdata; v.e_ctag = e_ctag; v.e_count = e_count;
    return v;
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_total++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic idle();
    bus.flush = 1'b0; bus.alloc_valid = 1'b0; bus.alloc_we = 1'b0; bus.alloc_dst = '0;
    bus.wb_we = 1'b0; bus.wb_tag = '0; bus.wb_dst = '0; bus.wb_data = '0; bus.rd_tag = '0;
  endtask

  task automatic do_reset();
    idle();
    rst = 1'b1;
    step();
    rst = 1'b0;
  endtask

  task automatic alloc(input logic we, input logic [4:0] dst);
    bus.alloc_valid = 1'b1; bus.alloc_we = we; bus.alloc_dst = dst;
  endtask

  task automatic wb(input logic [4:0] tag, input logic [4:0] dst, input logic [31:0] data);
    bus.wb_we = 1'b1; bus.wb_tag = tag; bus.wb_dst = dst; bus.wb_data = data;
  endtask

  initial begin
    //        rst fl av we dst wb tag dst data          rd chk rdy tag rdd rddata        cv cwe cdst cdata         ctag cnt
    vt[0]  = row(1, 0, 0, 0, 0, 0, 0, 0, 32'h0,        0, 0, 1, 0, 0, 32'h0,        0, 0, 0, 32'h0,        0, 0);
    vt[1]  = row(0, 0, 1, 1, 3, 0, 0, 0, 32'h0,        0, 1, 1, 0, 0, 32'h0,        0, 0, 0, 32'h0,        0, 0);
    vt[2]  = row(0, 0, 0, 0, 0, 1, 0, 3, 32'hDEADBEEF, 0, 1, 1, 1, 0, 32'h0,        0, 0, 0, 32'h0,        0, 1);
    vt[3]  = row(0, 0, 0, 0, 0, 0, 0, 0, 32'h0,        0, 1, 1, 1, 1, 32'hDEADBEEF, 0, 0, 0, 32'h0,        0, 1);
    vt[4]  = row(0, 0, 0, 0, 0, 0, 0, 0, 32'h0,        0, 1, 1, 1, 0, 32'h0,        1, 1, 3, 32'hDEADBEEF, 0, 0);
    vt[5]  = row(0, 0, 0, 0, 0, 0, 0, 0, 32'h0,        0, 1, 1, 1, 0, 32'h0,        0, 0, 0, 32'h0,        0, 0);
    vt[6]  = row(1, 0, 0, 0, 0, 0, 0, 0, 32'h0,        0, 0, 1, 0, 0, 32'h0,        0, 0, 0, 32'h0,        0, 0);
    vt[7]  = row(0, 0, 1, 1, 1, 0, 0, 0, 32'h0,        0, 1, 1, 0, 0, 32'h0,        0, 0, 0, 32'h0,        0, 0);
    vt[8]  = row(0, 0, 1, 1, 2, 0, 0, 0, 32'h0,        0, 1, 1, 1, 0, 32'h0,        0, 0, 0, 32'h0,        0, 1);
    vt[9]  = row(0, 0, 1, 0, 5, 0, 0, 0, 32'h0,        0, 1, 1, 2, 0, 32'h0,        0, 0, 0, 32'h0,        0, 2);
    vt[10] = row(0, 0, 0, 0, 0, 1, 2, 5, 32'h22,       2, 1, 1, 3, 0, 32'h0,        0, 0, 0, 32'h0,        0, 3);
    vt[11] = row(0, 0, 0, 0, 0, 1, 0, 1, 32'h11,       2, 1, 1, 3, 1, 32'h22,       0, 0, 0, 32'h0,        0, 3);
    vt[12] = row(0, 0, 0, 0, 0, 0, 0, 0, 32'h0,        0, 1, 1, 3, 1, 32'h11,       0, 0, 0, 32'h0,        0, 3);
    vt[13] = row(0, 0, 0, 0, 0, 1, 1, 2, 32'h33,       0, 1, 1, 3, 0, 32'h0,        1, 1, 1, 32'h11,       0, 2);
    vt[14] = row(0, 0, 0, 0, 0, 0, 0, 0, 32'h0,        1, 1, 1, 3, 1, 32'h33,       0, 0, 0, 32'h0,        0, 2);
    vt[15] = row(0, 0, 0, 0, 0, 0, 0, 0, 32'h0,        2, 1, 1, 3, 1, 32'h22,       1, 1, 2, 32'h33,       1, 1);
    vt[16] = row(0, 0, 0, 0, 0, 0, 0, 0, 32'h0,        2, 1, 1, 3, 0, 32'h0,        1, 0, 5, 32'h22,       2, 0);
    vt[17] = row(0, 0, 0, 0, 0, 1, 7, 0, 32'h55,       7, 1, 1, 3, 0, 32'h0,        0, 0, 0, 32'h0,        0, 0);
    vt[18] = row(0, 0, 0, 0, 0, 0, 0, 0, 32'h0,        7, 1, 1, 3, 0, 32'h0,        0, 0, 0, 32'h0,        0, 0);
    vt[19] = row(0, 0, 0, 0, 0, 0, 0, 0, 32'h0,        7, 1, 1, 3, 0, 32'h0,        0, 0, 0, 32'h0,        0, 0);

    idle();
    for (int i = 0; i < NV; i++) begin
      rst = vt[i].rst; bus.flush = vt[i].flush;
      bus.alloc_valid = vt[i].av; bus.alloc_we = vt[i].awe; bus.alloc_dst = vt[i].adst;
      bus.wb_we = vt[i].wbwe; bus.wb_tag = vt[i].wbtag; bus.wb_dst = vt[i].wbdst;
      bus.wb_data = vt[i].wbdata; bus.rd_tag = vt[i].rdtag;
      #1;
      if (vt[i].chk) begin
        chk($sformatf("v%0d alloc_ready", i), 32'(bus.alloc_ready), 32'(vt[i].e_ready));
        chk($sformatf("v%0d alloc_tag", i), 32'(bus.alloc_tag), 32'(vt[i].e_tag));
        chk($sformatf("v%0d rd_done", i), 32'(bus.rd_done), 32'(vt[i].e_rddone));
        if (vt[i].e_rddone)
          chk($sformatf("v%0d rd_data", i), bus.rd_data, vt[i].e_rddata);
        chk($sformatf("v%0d commit_valid", i), 32'(bus.commit_valid), 32'(vt[i].e_cv));
        chk($sformatf("v%0d commit_we", i), 32'(bus.commit_we), 32'(vt[i].e_cwe));
        chk($sformatf("v%0d commit_dst", i), 32'(bus.commit_dst), 32'(vt[i].e_cdst));
        chk($sformatf("v%0d commit_data", i), bus.commit_data, vt[i].e_cdata);
        chk($sformatf("v%0d commit_tag", i), 32'(bus.commit_tag), 32'(vt[i].e_ctag));
        chk($sformatf("v%0d count", i), 32'(bus.count), 32'(vt[i].e_count));
      end
      @(posedge clk);
      #0;
    end
    #1;
    rst = 1'b0;

    // Fill to capacity, overflow attempt, then free one slot and wrap the tail.
    do_reset();
    for (int i = 0; i < DEPTH; i++) begin
      alloc(1'b1, i[4:0]);
      chk($sformatf("fill%0d tag", i), 32'(bus.alloc_tag), 32'(i));
      chk($sformatf("fill%0d count", i), 32'(bus.count), 32'(i));
      chk($sformatf("fill%0d ready", i), 32'(bus.alloc_ready), 32'd1);
      step();
    end
    chk("full ready", 32'(bus.alloc_ready), 32'd0);
    chk("full count", 32'(bus.count), 32'd32);
    step();
    idle();
    chk("overflow count", 32'(bus.count), 32'd32);
    chk("overflow ready", 32'(bus.alloc_ready), 32'd0);
    wb(5'd0, 5'd0, 32'hA0);
    step();
    idle();
    chk("free cv early", 32'(bus.commit_valid), 32'd0);
    step();
    chk("free cv", 32'(bus.commit_valid), 32'd1);
    chk("free ctag", 32'(bus.commit_tag), 32'd0);
    chk("free cdata", bus.commit_data, 32'hA0);
    chk("free count", 32'(bus.count), 32'd31);
    chk("free ready", 32'(bus.alloc_ready), 32'd1);
    chk("wrap tag", 32'(bus.alloc_tag), 32'd0);
    alloc(1'b1, 5'd20);
    step();
    idle();
    chk("refill count", 32'(bus.count), 32'd32);
    chk("refill ready", 32'(bus.alloc_ready), 32'd0);

    // Full buffer with alloc held: refused during the commit cycle, accepted after.
    wb(5'd1, 5'd1, 32'hB1);
    alloc(1'b1, 5'd9);
    chk("hold ready0", 32'(bus.alloc_ready), 32'd0);
    step();
    bus.wb_we = 1'b0;
    chk("hold ready1", 32'(bus.alloc_ready), 32'd0);
    chk("hold count1", 32'(bus.count), 32'd32);
    chk("hold cv1", 32'(bus.commit_valid), 32'd0);
    step();
    chk("hold cv2", 32'(bus.commit_valid), 32'd1);
    chk("hold ctag2", 32'(bus.commit_tag), 32'd1);
    chk("hold cdata2", bus.commit_data, 32'hB1);
    chk("hold count2", 32'(bus.count), 32'd31);
    chk("hold ready2", 32'(bus.alloc_ready), 32'd1);
    chk("hold tag2", 32'(bus.alloc_tag), 32'd1);
    step();
    idle();
    chk("hold count3", 32'(bus.count), 32'd32);
    chk("hold ready3", 32'(bus.alloc_ready), 32'd0);
    chk("hold cv3", 32'(bus.commit_valid), 32'd0);

    // Flush with partially completed entries and same-cycle alloc/wb.
    do_reset();
    for (int i = 0; i < 8; i++) begin
      alloc(1'b1, i[4:0]);
      step();
    end
    idle();
    for (int t = 3; t < 6; t++) begin
      wb(t[4:0], t[4:0], 32'h100 + 32'(t));
      step();
    end
    idle();
    bus.rd_tag = 5'd4;
    #1;
    chk("pre-flush count", 32'(bus.count), 32'd8);
    chk("pre-flush rd_done", 32'(bus.rd_done), 32'd1);
    chk("pre-flush rd_data", bus.rd_data, 32'h104);
    chk("pre-flush cv", 32'(bus.commit_valid), 32'd0);
    bus.flush = 1'b1;
    alloc(1'b1, 5'd7);
    wb(5'd0, 5'd0, 32'h1);
    step();
    idle();
    bus.rd_tag = 5'd4;
    #1;
    chk("flush cv", 32'(bus.commit_valid), 32'd0);
    chk("flush count", 32'(bus.count), 32'd0);
    chk("flush tag", 32'(bus.alloc_tag), 32'd0);
    chk("flush ready", 32'(bus.alloc_ready), 32'd1);
    chk("flush rd_done", 32'(bus.rd_done), 32'd0);
    wb(5'd3, 5'd3, 32'h77);
    bus.rd_tag = 5'd3;
    step();
    idle();
    bus.rd_tag = 5'd3;
    #1;
    chk("stale wb rd_done", 32'(bus.rd_done), 32'd0);
    chk("stale wb count", 32'(bus.count), 32'd0);
    step();
    chk("stale wb cv", 32'(bus.commit_valid), 32'd0);
    chk("stale wb count2", 32'(bus.count), 32'd0);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end
endmodule
